// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/add_sub.sv
// 32-bit adder/subtractor; select=1 computes a-b, carry=1 then means no borrow.
module add_sub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        select,
  output logic [31:0] out,
  output logic        carry,
  output logic        zero
);

  logic [32:0] sum;

  assign sum   = {1'b0, a} + {1'b0, (select ? ~b : b)} + {32'b0, select};
  assign out   = sum[31:0];
  assign carry = sum[32];
  assign zero  = (sum[31:0] == 32'b0);

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider built around add_sub; one quotient bit per cycle.
// Optional signed mode enabled by defining SEQ_DIV_SIGNED_EN.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]       r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0]     quot_q, quot_d, rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH:0]       s;
  logic [WIDTH-1:0]     diff;
  logic                 carry, qb;
  logic                 zero_unused, r_msb_unused;
  logic [WIDTH-1:0]     a_mag, b_mag;

  assign s            = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign qb           = s[WIDTH] | carry;
  assign r_msb_unused = r_q[WIDTH];

  add_sub u_sub (
    .a      (s[WIDTH-1:0]),
    .b      (d_q),
    .select (1'b1),
    .out    (diff),
    .carry  (carry),
    .zero   (zero_unused)
  );

`ifdef SEQ_DIV_SIGNED_EN
  // Sign fix-up flags are captured with the operands and applied on DONE entry.
  logic negq_q, negq_d, negr_q, negr_d;
  assign a_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    if (state_q == S_RUN) begin
      r_d   = qb ? {1'b0, diff} : s;
      q_d   = {q_q[WIDTH-2:0], qb};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {DIV_CNT_W{1'b1}}) begin
        state_d = S_DONE;
        dbz_d   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
        quot_d  = negq_q ? -q_d : q_d;
        rem_d   = negr_q ? -r_d[WIDTH-1:0] : r_d[WIDTH-1:0];
`else
        quot_d  = q_d;
        rem_d   = r_d[WIDTH-1:0];
`endif
      end
    end else begin
      state_d = S_IDLE;
      if (start) begin
        if (divisor == '0) begin
          state_d = S_DONE;
          quot_d  = DIV_ZERO_QUOT;
          rem_d   = dividend;
          dbz_d   = 1'b1;
        end else begin
          state_d = S_RUN;
          r_d     = '0;
          q_d     = a_mag;
          d_d     = b_mag;
          cnt_d   = '0;
`ifdef SEQ_DIV_SIGNED_EN
          negq_d  = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d  = is_signed && dividend[WIDTH-1];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
